// File: rtl/dds_tune_pkg.sv
//------------------------------------------------------------------------------
// Module   : dds_tune_pkg
// Brief    : Shared request codes, FSM states and default tuning constants
//            for the DDS push-button tuning controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dds_tune_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    C_ADD = 4'd1,
    C_SUB = 4'd2,
    M_ADD = 4'd3,
    M_SUB = 4'd4,
    F_ADD = 4'd5,
    F_SUB = 4'd6,
    P_ADD = 4'd7,
    P_SUB = 4'd8
  } req_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  localparam int          c_hold_delay    = 25_000_000;
  localparam int          c_repeat_period = 5_000_000;
  localparam logic [31:0] c_fine_step     = 32'd86;
  localparam logic [31:0] c_mid_step      = 32'd85_899;
  localparam logic [31:0] c_coarse_step   = 32'd85_899_346;
  localparam logic [31:0] c_freq_min      = 32'd86;
  localparam logic [31:0] c_freq_max      = 32'd2_147_483_647;
  localparam logic [31:0] c_freq_init     = 32'd85_899_346;
  localparam int          c_phase_w       = 12;
  localparam int          c_phase_step    = 256;

  // req_n[7] is the highest-priority request (coarse add), req_n[0] the lowest.
  function automatic req_e req_encode(input logic [7:0] req_n);
    req_e r;
    r = NONE;
    if      (!req_n[7]) r = C_ADD;
    else if (!req_n[6]) r = C_SUB;
    else if (!req_n[5]) r = M_ADD;
    else if (!req_n[4]) r = M_SUB;
    else if (!req_n[3]) r = F_ADD;
    else if (!req_n[2]) r = F_SUB;
    else if (!req_n[1]) r = P_ADD;
    else if (!req_n[0]) r = P_SUB;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_repeat.sv
//------------------------------------------------------------------------------
// Module   : key_repeat
// Brief    : Priority-encodes the step requests and turns a press or a hold
//            into registered one-cycle step strobes with auto-repeat.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_repeat
  import dds_tune_pkg::*;
#(
  parameter int HOLD_DELAY    = c_hold_delay,
  parameter int REPEAT_PERIOD = c_repeat_period
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req_n,
  output logic       step,
  output logic [3:0] code
);

  localparam int c_cnt_max = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int c_cnt_w   = $clog2(c_cnt_max);

  localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(HOLD_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_repeat_last = c_cnt_w'(REPEAT_PERIOD - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  req_e                 r_cur;
  req_e                 w_cur_nxt;
  req_e                 w_sel;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 r_step;
  logic                 w_step_nxt;
  req_e                 r_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cur   <= NONE;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_code  <= NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_code  <= w_cur_nxt;
    end
  end

  always_comb begin
    w_sel       = req_encode(req_n);
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_sel != NONE) begin
          w_step_nxt  = 1'b1;
          w_cur_nxt   = w_sel;
          w_cnt_nxt   = '0;
          w_state_nxt = DELAY;
        end
      end

      DELAY: begin
        if (w_sel != r_cur) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_hold_last) begin
          w_step_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      REPEAT: begin
        if (w_sel != r_cur) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_repeat_last) begin
          w_step_nxt = 1'b1;
          w_cnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign step = r_step;
  assign code = r_code;

endmodule

`default_nettype wire

// File: rtl/dds_tune_ctrl.sv
//------------------------------------------------------------------------------
// Module   : dds_tune_ctrl
// Brief    : DDS tuning controller: saturating FTW and wrapping phase offset
//            driven by push-button step requests with auto-repeat.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dds_tune_ctrl
  import dds_tune_pkg::*;
#(
  parameter int          HOLD_DELAY    = c_hold_delay,
  parameter int          REPEAT_PERIOD = c_repeat_period,
  parameter logic [31:0] FINE_STEP     = c_fine_step,
  parameter logic [31:0] MID_STEP      = c_mid_step,
  parameter logic [31:0] COARSE_STEP   = c_coarse_step,
  parameter logic [31:0] FREQ_MIN      = c_freq_min,
  parameter logic [31:0] FREQ_MAX      = c_freq_max,
  parameter logic [31:0] FREQ_INIT     = c_freq_init,
  parameter int          PHASE_W       = c_phase_w,
  parameter int          PHASE_STEP    = c_phase_step
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Switchadd_n,
  input  logic               Switchsub_n,
  input  logic               SwitchMicroadd_n,
  input  logic               SwitchMicrosub_n,
  input  logic               SwitchNanoadd_n,
  input  logic               SwitchNanosub_n,
  input  logic               Phaseadd_n,
  input  logic               Phasesub_n,
  output logic [31:0]        ftw,
  output logic [PHASE_W-1:0] phase_off,
  output logic               ftw_update,
  output logic               phase_update,
  output logic               at_fmax,
  output logic               at_fmin
);

  localparam logic [PHASE_W-1:0] c_phase_inc = PHASE_W'(PHASE_STEP);

  logic [7:0]         w_req_n;
  logic               w_step;
  logic [3:0]         w_code;
  req_e               w_code_e;

  logic               w_is_freq;
  logic               w_is_phase;
  logic               w_is_add;
  logic [32:0]        w_fstep;
  logic [32:0]        w_sum;
  logic [32:0]        w_floor;
  logic [31:0]        w_ftw_nxt;
  logic [PHASE_W-1:0] w_phase_nxt;

  logic [31:0]        r_ftw;
  logic [PHASE_W-1:0] r_phase;
  logic               r_ftw_upd;
  logic               r_phase_upd;
  logic               r_at_fmax;
  logic               r_at_fmin;

  assign w_req_n = {Switchadd_n, Switchsub_n, SwitchMicroadd_n, SwitchMicrosub_n,
                    SwitchNanoadd_n, SwitchNanosub_n, Phaseadd_n, Phasesub_n};

  key_repeat #(
    .HOLD_DELAY    (HOLD_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_key_repeat (
    .clk   (clk),
    .reset (reset),
    .req_n (w_req_n),
    .step  (w_step),
    .code  (w_code)
  );

  always_comb begin
    w_code_e   = req_e'(w_code);
    w_is_freq  = 1'b0;
    w_is_phase = 1'b0;
    w_is_add   = 1'b0;
    w_fstep    = '0;

    if (w_step) begin
      case (w_code_e)
        C_ADD: begin w_is_freq = 1'b1; w_is_add = 1'b1; w_fstep = {1'b0, COARSE_STEP}; end
        C_SUB: begin w_is_freq = 1'b1;                  w_fstep = {1'b0, COARSE_STEP}; end
        M_ADD: begin w_is_freq = 1'b1; w_is_add = 1'b1; w_fstep = {1'b0, MID_STEP};    end
        M_SUB: begin w_is_freq = 1'b1;                  w_fstep = {1'b0, MID_STEP};    end
        F_ADD: begin w_is_freq = 1'b1; w_is_add = 1'b1; w_fstep = {1'b0, FINE_STEP};   end
        F_SUB: begin w_is_freq = 1'b1;                  w_fstep = {1'b0, FINE_STEP};   end
        P_ADD: begin w_is_phase = 1'b1; w_is_add = 1'b1; end
        P_SUB: begin w_is_phase = 1'b1;                  end
        default: ;
      endcase
    end
  end

  // 33-bit sums keep the carry so the clamp test cannot wrap.
  always_comb begin
    w_sum       = {1'b0, r_ftw} + w_fstep;
    w_floor     = {1'b0, FREQ_MIN} + w_fstep;
    w_ftw_nxt   = r_ftw;
    w_phase_nxt = r_phase;

    if (w_is_freq) begin
      if (w_is_add) begin
        w_ftw_nxt = (w_sum > {1'b0, FREQ_MAX}) ? FREQ_MAX : w_sum[31:0];
      end else begin
        w_ftw_nxt = ({1'b0, r_ftw} < w_floor) ? FREQ_MIN : (r_ftw - w_fstep[31:0]);
      end
    end

    if (w_is_phase) begin
      w_phase_nxt = w_is_add ? (r_phase + c_phase_inc) : (r_phase - c_phase_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ftw       <= FREQ_INIT;
      r_phase     <= '0;
      r_ftw_upd   <= 1'b0;
      r_phase_upd <= 1'b0;
      r_at_fmax   <= (FREQ_INIT == FREQ_MAX);
      r_at_fmin   <= (FREQ_INIT == FREQ_MIN);
    end else begin
      r_ftw       <= w_ftw_nxt;
      r_phase     <= w_phase_nxt;
      r_ftw_upd   <= (w_ftw_nxt != r_ftw);
      r_phase_upd <= (w_phase_nxt != r_phase);
      r_at_fmax   <= (w_ftw_nxt == FREQ_MAX);
      r_at_fmin   <= (w_ftw_nxt == FREQ_MIN);
    end
  end

  assign ftw          = r_ftw;
  assign phase_off    = r_phase;
  assign ftw_update   = r_ftw_upd;
  assign phase_update = r_phase_upd;
  assign at_fmax      = r_at_fmax;
  assign at_fmin      = r_at_fmin;

endmodule

`default_nettype wire

// File: tb/tb_dds_tune_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_dds_tune_ctrl
// Brief    : Directed self-checking bench for dds_tune_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dds_tune_ctrl;

  localparam int          c_phase_w = 12;
  localparam logic [31:0] c_init    = 32'd85_899_346;
  localparam logic [31:0] c_coarse  = 32'd85_899_346;
  localparam logic [31:0] c_mid     = 32'd85_899;
  localparam logic [31:0] c_fine    = 32'd86;
  localparam logic [31:0] c_fmin    = 32'd86;
  localparam logic [31:0] c_fmax    = 32'd2_147_483_647;

  // bit7 Switchadd .. bit0 Phasesub
  localparam int b_cadd = 7;
  localparam int b_csub = 6;
  localparam int b_madd = 5;
  localparam int b_fadd = 3;
  localparam int b_padd = 1;
  localparam int b_psub = 0;

  logic                 clk;
  logic                 reset;
  logic [7:0]           req_n;
  logic [31:0]          ftw;
  logic [c_phase_w-1:0] phase_off;
  logic                 ftw_update;
  logic                 phase_update;
  logic                 at_fmax;
  logic                 at_fmin;

  int passed;
  int failed;
  int total;

  dds_tune_ctrl #(
    .HOLD_DELAY    (4),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .Switchadd_n      (req_n[7]),
    .Switchsub_n      (req_n[6]),
    .SwitchMicroadd_n (req_n[5]),
    .SwitchMicrosub_n (req_n[4]),
    .SwitchNanoadd_n  (req_n[3]),
    .SwitchNanosub_n  (req_n[2]),
    .Phaseadd_n       (req_n[1]),
    .Phasesub_n       (req_n[0]),
    .ftw              (ftw),
    .phase_off        (phase_off),
    .ftw_update       (ftw_update),
    .phase_update     (phase_update),
    .at_fmax          (at_fmax),
    .at_fmin          (at_fmin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Single press: one sampled-low edge, then release; the update is visible on return.
  task automatic press(input logic [7:0] mask_n);
    req_n = mask_n;
    tick();
    req_n = 8'hFF;
    tick();
  endtask

  logic [11:0] pulses;
  logic [7:0]  m;

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    reset  = 1'b1;
    req_n  = 8'hFF;
    tick();
    tick();

    chk("reset_ftw", ftw, c_init);
    chk("reset_phase", phase_off, 0);
    chk("reset_ftw_upd", ftw_update, 0);
    chk("reset_phase_upd", phase_update, 0);
    chk("reset_fmax", at_fmax, 0);
    chk("reset_fmin", at_fmin, 0);
    reset = 1'b0;
    tick();

    // Fine up, single press
    m = 8'hFF; m[b_fadd] = 1'b0;
    press(m);
    chk("fine_ftw", ftw, c_init + c_fine);
    chk("fine_upd", ftw_update, 1);
    tick();
    chk("fine_upd_drop", ftw_update, 0);
    tick(); tick();
    chk("fine_hold_val", ftw, c_init + c_fine);

    // Mid up held 12 cycles: updates land on ticks 2, 6, 9, 12
    m = 8'hFF; m[b_madd] = 1'b0;
    req_n = m;
    pulses = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      pulses[i] = ftw_update;
    end
    req_n = 8'hFF;
    tick();
    chk("mid_pulse_pattern", pulses, 12'h922);
    chk("mid_final_ftw", ftw, c_init + c_fine + 4 * c_mid);
    tick();
    chk("mid_no_more", ftw_update, 0);

    // Coarse up held until saturation
    m = 8'hFF; m[b_cadd] = 1'b0;
    req_n = m;
    for (int i = 0; i < 100; i++) tick();
    req_n = 8'hFF;
    tick(); tick(); tick();
    chk("sat_ftw", ftw, c_fmax);
    chk("sat_fmax", at_fmax, 1);
    chk("sat_fmin", at_fmin, 0);
    press(m);
    chk("sat_again_ftw", ftw, c_fmax);
    chk("sat_again_upd", ftw_update, 0);

    // Coarse down from max is exact
    m = 8'hFF; m[b_csub] = 1'b0;
    press(m);
    chk("sub_ftw", ftw, c_fmax - c_coarse);
    chk("sub_fmax_clear", at_fmax, 0);

    // Phase wrap both directions
    m = 8'hFF; m[b_psub] = 1'b0;
    press(m);
    chk("psub_val", phase_off, 3840);
    chk("psub_upd", phase_update, 1);
    chk("psub_no_ftw_upd", ftw_update, 0);
    m = 8'hFF; m[b_padd] = 1'b0;
    press(m);
    chk("padd_val", phase_off, 0);
    chk("padd_upd", phase_update, 1);

    // Reset, then coarse down + phase up together: priority and min clamp
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_ftw", ftw, c_init);
    m = 8'hFF; m[b_csub] = 1'b0; m[b_padd] = 1'b0;
    press(m);
    chk("prio_ftw", ftw, c_fmin);
    chk("prio_fmin", at_fmin, 1);
    chk("prio_ftw_upd", ftw_update, 1);
    chk("prio_phase", phase_off, 0);
    chk("prio_phase_upd", phase_update, 0);
    tick();

    // Reset mid-REPEAT with the request still held
    m = 8'hFF; m[b_madd] = 1'b0;
    req_n = m;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_ftw", ftw, c_init);
    chk("rst_mid_upd", ftw_update, 0);
    chk("rst_mid_fmin", at_fmin, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ftw_a", ftw, c_init);
    tick();
    chk("post_rst_ftw_b", ftw, c_init + c_mid);
    chk("post_rst_upd", ftw_update, 1);
    req_n = 8'hFF;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dds_tune_ctrl.md
Name: dds_tune_ctrl

Overview:
- Sits directly downstream of the push-button decoder. Consumes its active-low step-request levels: coarse/mid/fine frequency add/sub and phase add/sub.
- Turns each press into one tuning step. Holding a request auto-repeats the step.
- Owns the DDS frequency tuning word (FTW) and phase offset registers that feed the phase accumulator.
- Frequency is saturating. Phase wraps.

Parameters:
- HOLD_DELAY, 25_000_000, cycles a request must stay held after the first step before auto-repeat starts (0.5 s at 50 MHz); must be ≥2.
- REPEAT_PERIOD, 5_000_000, cycles between auto-repeat steps; must be ≥2.
- FINE_STEP, 86, FTW increment for fine (≈1 Hz at 50 MHz).
- MID_STEP, 85_899, FTW increment for mid (≈1 kHz).
- COARSE_STEP, 85_899_346, FTW increment for coarse (≈1 MHz).
- FREQ_MIN, 86, lowest legal FTW.
- FREQ_MAX, 2_147_483_647, highest legal FTW (Nyquist).
- FREQ_INIT, 85_899_346, FTW after reset.
- PHASE_W, 12, phase offset width.
- PHASE_STEP, 256, phase increment (22.5° at PHASE_W=12).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Switchadd_n  in  1  coarse freq up request, active-low level
- Switchsub_n  in  1  coarse freq down request, active-low
- SwitchMicroadd_n  in  1  mid freq up request, active-low
- SwitchMicrosub_n  in  1  mid freq down request, active-low
- SwitchNanoadd_n  in  1  fine freq up request, active-low
- SwitchNanosub_n  in  1  fine freq down request, active-low
- Phaseadd_n  in  1  phase up request, active-low
- Phasesub_n  in  1  phase down request, active-low
- ftw  out  32  frequency tuning word
- phase_off  out  PHASE_W  phase offset
- ftw_update  out  1  one-cycle pulse: ftw changed this cycle
- phase_update  out  1  one-cycle pulse: phase_off changed this cycle
- at_fmax  out  1  level: ftw == FREQ_MAX
- at_fmin  out  1  level: ftw == FREQ_MIN

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (reset=1 sampled on clk rising edge).
- Inputs are already debounced and synchronous to clk.
- All outputs are registered.
- Reset values:
  - ftw = FREQ_INIT, phase_off = 0.
  - ftw_update = 0, phase_update = 0.
  - at_fmax and at_fmin reflect FREQ_INIT.
  - FSM = IDLE, counter = 0.
- Request select: a fixed priority encoder over active (low) inputs produces code sel, or NONE. Priority, highest first: Switchadd, Switchsub, Microadd, Microsub, Nanoadd, Nanosub, Phaseadd, Phasesub. Lower-priority simultaneous requests are ignored.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE:
    - sel≠NONE → apply step(sel), latch cur=sel, counter=0, go DELAY.
    - Otherwise stay.
  - DELAY:
    - sel≠cur (release or change) → IDLE, no step this cycle.
    - Else if counter==HOLD_DELAY-1 → step, counter=0, go REPEAT.
    - Else counter+1.
  - REPEAT:
    - sel≠cur → IDLE, no step.
    - Else if counter==REPEAT_PERIOD-1 → step, counter=0.
    - Else counter+1.
- Changing to a different request while one is held costs one IDLE cycle, then the new request steps.
- Latency: request sampled low at edge k → ftw/phase_off updated at edge k+1. The update pulse is high for the cycle following edge k+1.
- Freq step arithmetic uses a 33-bit intermediate:
  - Add: ftw + S > FREQ_MAX → ftw = FREQ_MAX.
  - Sub: ftw < FREQ_MIN + S → ftw = FREQ_MIN.
  - Otherwise ftw ± S exactly.
- Phase step: phase_off ± PHASE_STEP modulo 2^PHASE_W. Wrap-around is not an error.
- ftw_update and phase_update pulse only if the value actually changed. A step at saturation produces no pulse.
- at_fmax and at_fmin are registered and updated in the same cycle as ftw.
- At most one step per cycle. Phase and frequency never change in the same cycle.
- Reset mid-hold: FSM returns to IDLE and outputs return to reset values. If a request is still held when reset deasserts, it steps in the first cycle after reset (treated as a new press).
- Counter width is $clog2 of max(HOLD_DELAY, REPEAT_PERIOD). The counter never exceeds its terminal value.

Decomposition:
- Package dds_tune_pkg:
  - request code enum (NONE, C_ADD, C_SUB, M_ADD, M_SUB, F_ADD, F_SUB, P_ADD, P_SUB);
  - FSM state enum;
  - default step constants.
- One sub-module, key_repeat: priority encoder plus IDLE/DELAY/REPEAT FSM and counter. It outputs a one-cycle step strobe and the code.
- The top level holds the saturating FTW and wrapping phase datapath.

Test Plan:
- Reset, all inputs high → ftw=85_899_346, phase_off=0, pulses 0, at_fmax=0, at_fmin=0.
- Nanoadd low for 1 cycle → next cycle ftw=85_899_432, ftw_update=1 for one cycle. No further change.
- HOLD_DELAY=4, REPEAT_PERIOD=3, Microadd held 12 cycles → steps at cycles 1, 5, 8, 11. Final ftw=FREQ_INIT+4·85_899.
- ftw preloaded to 2_100_000_000, Switchadd press → ftw=2_147_483_647, at_fmax=1. Second press → no change, no ftw_update.
- phase_off=0, Phasesub press → phase_off=3840. From 3840, Phaseadd → 0. Both cases phase_update=1.
- Switchsub and Phaseadd both low together → only the coarse down step (ftw=FREQ_INIT−COARSE_STEP=0, clamped to 86). phase_off unchanged. Reset asserted mid-REPEAT → ftw back to FREQ_INIT next cycle.
